// File: rtl/alu_operand_seq_pkg.sv
// Shared opcode constants, FSM state encoding and flag bit positions for the ALU operand sequencer.
package alu_operand_seq_pkg;

  localparam int unsigned OP_ABS = 0;
  localparam int unsigned OP_SHL = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_XOR = 4;
  localparam int unsigned OP_NOT = 5;
  localparam int unsigned OP_ADD = 6;
  localparam int unsigned OP_SUB = 7;

  localparam int FLAG_OV    = 3;
  localparam int FLAG_SIGN  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 0;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    EXEC  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Ops that need a second operand word before executing.
  function automatic logic op_is_binary(input int unsigned op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) ||
           (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic op_is_arith(input int unsigned op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_operand_seq_flag_gen.sv
// Combinational status-flag generation from the ALU result and the registered operands.
module alu_flag_gen
  import alu_operand_seq_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int OPW   = 3
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       b_msbs,
  input  logic [WIDTH-1:0] z,
  input  logic             carry,
  input  logic             ov,
  output logic [3:0]       flags
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    flags             = '0;
    flags[FLAG_ZERO]  = (z == '0);
    flags[FLAG_SIGN]  = z[WIDTH-1];
    if (op_is_arith(int'(op))) begin
      flags[FLAG_CARRY] = carry;
      flags[FLAG_OV]    = ov;
    end else if (int'(op) == OP_ABS) begin
      // |most negative| is not representable.
      flags[FLAG_OV]    = (a == MOST_NEG);
    end else if (int'(op) == OP_SHL) begin
      flags[FLAG_OV]    = b_msbs[1] ^ b_msbs[0];
    end
  end

endmodule

// File: rtl/alu_operand_seq.sv
// Collects one or two operand words, presents them to an external ALU, then captures and holds the result.
// Optional build macro ALU_SEQ_STICKY_OV_EN adds sticky_clr / sticky_ov (sticky overflow indicator).
module alu_operand_seq
  import alu_operand_seq_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [OPW-1:0]   in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_carry,
  input  logic             alu_ov,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic [3:0]       out_flags
`ifdef ALU_SEQ_STICKY_OV_EN
  ,
  input  logic             sticky_clr,
  output logic             sticky_ov
`endif
);

  // Handshakes: a word transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] out_z_q, out_z_d;
  logic [3:0]       out_flags_q, out_flags_d;
  logic [3:0]       flags;

  alu_flag_gen #(.WIDTH(WIDTH), .OPW(OPW)) u_flag_gen (
    .op     (alu_op_q),
    .a      (alu_a_q),
    .b_msbs (alu_b_q[WIDTH-1 -: 2]),
    .z      (alu_z),
    .carry  (alu_carry),
    .ov     (alu_ov),
    .flags  (flags)
  );

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    out_z_d     = out_z_q;
    out_flags_d = out_flags_q;
    in_ready    = (state_q == GET_A) || (state_q == GET_B);
    out_valid   = (state_q == HOLD);
    case (state_q)
      GET_A: begin
        if (in_valid) begin
          alu_op_d = in_op;
          if (op_is_binary(int'(in_op))) begin
            alu_a_d = in_data;
            state_d = GET_B;
          end else if (int'(in_op) == OP_SHL) begin
            alu_a_d = '0;
            alu_b_d = in_data;
            state_d = EXEC;
          end else begin
            alu_a_d = in_data;
            alu_b_d = '0;
            state_d = EXEC;
          end
        end
      end
      GET_B: begin
        if (in_valid) begin
          alu_b_d = in_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        out_z_d     = alu_z;
        out_flags_d = flags;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = GET_A;
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= GET_A;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      out_z_q     <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      out_z_q     <= out_z_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign out_z     = out_z_q;
  assign out_flags = out_flags_q;

`ifdef ALU_SEQ_STICKY_OV_EN
  logic sticky_q, sticky_d;

  // Setting in EXEC wins over a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q & ~sticky_clr;
    if ((state_q == EXEC) && flags[FLAG_OV]) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_ov = sticky_q;
`endif

endmodule

// File: tb/tb_alu_operand_seq.sv
// Randomized scoreboard bench for alu_operand_seq with an ALU stub and an integer-arithmetic reference model.
module tb_alu_operand_seq;

  localparam int W    = 12;
  localparam int OPW  = 3;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [OPW-1:0] in_op;
  logic [W-1:0]   alu_a, alu_b, alu_z;
  logic [OPW-1:0] alu_op;
  logic           alu_carry, alu_ov;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_z;
  logic [3:0]     out_flags;
`ifdef ALU_SEQ_STICKY_OV_EN
  logic           sticky_clr;
  logic           sticky_ov;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit bp_force = 1'b0;

  logic [W+3:0] exp_q[$];
  int           lat_q[$];

  alu_operand_seq #(.WIDTH(W), .OPW(OPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_z     (alu_z),
    .alu_carry (alu_carry),
    .alu_ov    (alu_ov),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_flags (out_flags)
`ifdef ALU_SEQ_STICKY_OV_EN
    ,
    .sticky_clr (sticky_clr),
    .sticky_ov  (sticky_ov)
`endif
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stub; carry/ov carry junk for ops whose flags must ignore them.
  always_comb begin
    alu_z     = '0;
    alu_carry = ^alu_a;
    alu_ov    = ~^alu_b;
    case (alu_op)
      3'd0: alu_z = alu_a[W-1] ? (~alu_a + 1'b1) : alu_a;
      3'd1: alu_z = {alu_b[W-2:0], 1'b0};
      3'd2: alu_z = alu_a & alu_b;
      3'd3: alu_z = alu_a | alu_b;
      3'd4: alu_z = alu_a ^ alu_b;
      3'd5: alu_z = ~alu_a;
      3'd6: begin
        {alu_carry, alu_z} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_ov = (alu_a[W-1] == alu_b[W-1]) && (alu_z[W-1] != alu_a[W-1]);
      end
      default: begin
        alu_z     = alu_a - alu_b;
        alu_carry = (alu_a < alu_b);
        alu_ov    = (alu_a[W-1] != alu_b[W-1]) && (alu_z[W-1] != alu_a[W-1]);
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: {ov, sign, carry, zero, z} from opcode and raw words.
  function automatic logic [W+3:0] model(input int op, input int w1, input int w2);
    int a, b, sa, sb, r, z;
    bit c, o;
    logic [W-1:0] zz;
    a  = (op == 1) ? 0 : w1;
    b  = (op == 0 || op == 5) ? 0 : ((op == 1) ? w1 : w2);
    sa = (a >= HALF) ? a - FULL : a;
    sb = (b >= HALF) ? b - FULL : b;
    case (op)
      0: r = (sa < 0) ? -sa : sa;
      1: r = b * 2;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: r = a + b;
      default: r = a - b;
    endcase
    z = r & (FULL - 1);
    c = (op == 6) ? (a + b >= FULL) : ((op == 7) ? (a < b) : 1'b0);
    case (op)
      0: o = (a == HALF);
      1: o = (b >= HALF) != ((b % HALF) >= HALF / 2);
      6: o = (sa + sb > HALF - 1) || (sa + sb < -HALF);
      7: o = (sa - sb > HALF - 1) || (sa - sb < -HALF);
      default: o = 1'b0;
    endcase
    zz = z[W-1:0];
    return {o, (z >= HALF), c, (z == 0), zz};
  endfunction

  // Driver: present one word, wait (bounded) for acceptance.
  task automatic put_word(input logic [W-1:0] d, input logic [OPW-1:0] op, input bit last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
    end else if (last) begin
      lat_q.push_back(cyc + 2);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_op    = OPW'($urandom);
  endtask

  task automatic run_txn(input int op, input int w1, input int w2);
    bit two;
    two = !(op == 0 || op == 1 || op == 5);
    exp_q.push_back(model(op, w1, w2));
    put_word(W'(w1), OPW'(op), !two);
    if (two) put_word(W'(w2), OPW'($urandom), 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (8) @(negedge clk);
  endtask

  // Monitor / scoreboard, also owns out_ready.
  bit            vld_prev = 1'b0;
  int            hold_cnt, hold_tgt, vld_len;
  logic [W-1:0]  held_z;
  logic [3:0]    held_f;

  always @(negedge clk) begin
    if (rst) begin
      vld_prev  = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      if (out_valid && !vld_prev) begin
        if (lat_q.size() == 0 || exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          logic [W+3:0] e;
          e = exp_q.pop_front();
          chk("latency_cycle", 32'(cyc), 32'(lat_q.pop_front()));
          chk("out_z", 32'(out_z), 32'(e[W-1:0]));
          chk("out_flags", 32'(out_flags), 32'(e[W+3:W]));
        end
        held_z   = out_z;
        held_f   = out_flags;
        hold_cnt = 0;
        vld_len  = 0;
        hold_tgt = bp_force ? 5 : $urandom_range(0, 2);
      end
      if (out_valid) begin
        vld_len++;
        chk("in_ready_in_hold", 32'(in_ready), 32'd0);
        if (vld_len > 1) begin
          chk("hold_z_stable", 32'(out_z), 32'(held_z));
          chk("hold_flags_stable", 32'(out_flags), 32'(held_f));
        end
        if (hold_cnt < hold_tgt) begin
          out_ready = 1'b0;
          hold_cnt++;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        if (vld_prev) chk("hold_length", 32'(vld_len), 32'(hold_tgt + 1));
        out_ready = 1'($urandom_range(0, 1));
      end
      vld_prev = out_valid;
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_op    = '0;
`ifdef ALU_SEQ_STICKY_OV_EN
    sticky_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_out_z", 32'(out_z), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
`ifdef ALU_SEQ_STICKY_OV_EN
    chk("rst_sticky", 32'(sticky_ov), 32'd0);
`endif
    rst = 1'b0;

    // Signed-overflowing add, then a zero-result subtract.
    run_txn(6, 12'h7FF, 12'h001);
    run_txn(7, 12'h005, 12'h005);
    drain();

    // Unary shift: a single word feeds alu_b.
    run_txn(1, 12'h400, 0);
    chk("unary_alu_b", 32'(alu_b), 32'h400);
    chk("unary_alu_a", 32'(alu_a), 32'h0);
    chk("unary_alu_op", 32'(alu_op), 32'd1);
    chk("unary_no_2nd_word", 32'(in_ready), 32'd0);
    drain();

    // Abs of the most negative value, and a long downstream stall.
    run_txn(0, 12'h800, 0);
    bp_force = 1'b1;
    run_txn(4, 12'hA5A, 12'h0FF);
    drain();
    bp_force = 1'b0;

`ifdef ALU_SEQ_STICKY_OV_EN
    run_txn(6, 12'h7FF, 12'h001);
    run_txn(2, 12'h0F0, 12'h3C3);
    drain();
    chk("sticky_held", 32'(sticky_ov), 32'd1);
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    chk("sticky_cleared", 32'(sticky_ov), 32'd0);
`endif

    // Reset while waiting for the second word.
    put_word(12'h123, 3'd2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_alu_a", 32'(alu_a), 32'd0);
    run_txn(2, 12'hF0F, 12'h3CC);
    drain();

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      run_txn($urandom_range(0, 7), $urandom_range(0, FULL - 1), $urandom_range(0, FULL - 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    chk("latency_queue_empty", 32'(lat_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
